// File: rtl/spi_csn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_csn_sequencer
//  Description : Avalon-MM slave that runs single-byte SPI mode-0 transfers
//                with chip-select setup/hold timing, optional chip-select
//                hold-over between bytes and a maskable done interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_csn_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int NUM_CS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_csn
);

    localparam int c_DIV_W    = $clog2(CLK_DIV) + 1;
    localparam int c_WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX) + 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_SETUP_LAST = c_WAIT_W'(CS_SETUP - 1);
    localparam logic [c_WAIT_W-1:0] c_HOLD_LAST  = c_WAIT_W'(CS_HOLD - 1);
    localparam logic [NUM_CS-1:0]   c_CSN_IDLE   = {NUM_CS{1'b1}};

    localparam logic [1:0] c_ADDR_TXRX    = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] c_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] c_ADDR_CONTROL = 2'd3;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_SETUP = 2'd1,
        c_SHIFT = 2'd2,
        c_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_tx;
    logic [7:0]          r_rx;
    logic [7:0]          r_rx_sh;
    logic [NUM_CS-1:0]   r_cs_sel;
    logic [NUM_CS-1:0]   r_cs_act;
    logic                r_hold_cs;
    logic                r_held;
    logic                r_mask;
    logic                r_busy;
    logic                r_done;
    logic                r_ovr;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_WAIT_W-1:0] r_wait;
    logic [2:0]          r_bit;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_csn;
    logic [31:0]         r_readdata;
    logic [31:0]         w_rdata;

    logic w_wr, w_wr_txrx, w_wr_status, w_wr_mask, w_wr_ctrl;
    logic w_start, w_div_tc, w_rise, w_fall, w_last_fall;
    logic w_setup_done, w_hold_done, w_release;
    logic w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_txrx   = w_wr && (address == c_ADDR_TXRX);
    assign w_wr_status = w_wr && (address == c_ADDR_STATUS);
    assign w_wr_mask   = w_wr && (address == c_ADDR_IRQMASK);
    assign w_wr_ctrl   = w_wr && (address == c_ADDR_CONTROL);
    assign w_unused_wd = ^writedata[31:9];

    // IDLE with busy set means a start was accepted on the previous edge
    assign w_start      = (r_state == c_IDLE) && r_busy;
    assign w_div_tc     = (r_div == c_DIV_LAST);
    assign w_rise       = (r_state == c_SHIFT) && w_div_tc && !r_sclk;
    assign w_fall       = (r_state == c_SHIFT) && w_div_tc && r_sclk;
    assign w_last_fall  = w_fall && (r_bit == 3'd7);
    assign w_setup_done = (r_state == c_SETUP) && (r_wait == c_SETUP_LAST);
    assign w_hold_done  = (r_state == c_HOLD) && (r_wait == c_HOLD_LAST);
    // Dropping hold_cs while parked on a held chip select frees it at once
    assign w_release    = (r_state == c_IDLE) && !r_busy && r_held &&
                          w_wr_ctrl && !writedata[8];

    assign irq      = r_done & r_mask;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_csn  = r_csn;
    assign readdata = r_readdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode; a held chip select skips the setup phase
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start)      w_state_next = r_held ? c_SHIFT : c_SETUP;
            c_SETUP: if (w_setup_done) w_state_next = c_SHIFT;
            c_SHIFT: if (w_last_fall)  w_state_next = c_HOLD;
            c_HOLD:  if (w_hold_done)  w_state_next = c_IDLE;
            default:                   w_state_next = c_IDLE;
        endcase
    end

    // Register file writes and status flags; done set wins over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx      <= '0;
            r_cs_sel  <= '0;
            r_cs_act  <= '0;
            r_hold_cs <= 1'b0;
            r_mask    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_wr_txrx) begin
                if (r_busy) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_tx     <= writedata[7:0];
                    r_cs_act <= r_cs_sel;
                    r_busy   <= 1'b1;
                end
            end
            if (w_wr_status) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_wr_mask) r_mask <= writedata[0];
            if (w_wr_ctrl) begin
                r_cs_sel  <= writedata[NUM_CS-1:0];
                r_hold_cs <= writedata[8];
            end
            if (w_hold_done) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Serial datapath: timing counters, sclk/mosi/csn drive and miso capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_wait  <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_csn   <= c_CSN_IDLE;
            r_held  <= 1'b0;
            r_rx_sh <= '0;
            r_rx    <= '0;
        end else begin
            if (w_state_next != r_state)                      r_wait <= '0;
            else if (r_state == c_SETUP || r_state == c_HOLD) r_wait <= r_wait + 1'b1;

            if (r_state == c_SHIFT) r_div <= w_div_tc ? '0 : r_div + 1'b1;
            else                    r_div <= '0;

            if (w_start) begin
                r_csn   <= ~r_cs_act;
                r_mosi  <= r_tx[7];
                r_bit   <= '0;
                r_sclk  <= 1'b0;
                r_rx_sh <= '0;
            end
            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_rx_sh <= {r_rx_sh[6:0], spi_miso};
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (!w_last_fall) begin
                    r_bit  <= r_bit + 3'd1;
                    r_mosi <= r_tx[3'd6 - r_bit];
                end
            end
            if (w_hold_done) begin
                r_rx   <= r_rx_sh;
                r_mosi <= 1'b0;
                r_held <= r_hold_cs;
                if (!r_hold_cs) r_csn <= c_CSN_IDLE;
            end
            if (w_release) begin
                r_csn  <= c_CSN_IDLE;
                r_held <= 1'b0;
            end
        end
    end

    // Read mux; unused bits read as zero
    always_comb begin
        w_rdata = '0;
        case (address)
            c_ADDR_TXRX:    w_rdata[7:0] = r_rx;
            c_ADDR_STATUS:  w_rdata[2:0] = {r_ovr, r_done, r_busy};
            c_ADDR_IRQMASK: w_rdata[0]   = r_mask;
            default: begin
                w_rdata[NUM_CS-1:0] = r_cs_sel;
                w_rdata[8]          = r_hold_cs;
            end
        endcase
    end

    // Registered read data, one cycle latency, no side effects
    always_ff @(posedge clk) begin
        if (reset) r_readdata <= '0;
        else       r_readdata <= w_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_csn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_csn_sequencer
//  Description : Self-checking bench for spi_csn_sequencer; expected rx bytes
//                and mosi bit streams are queued at stimulus time and popped
//                when the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_csn_sequencer;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int NUM_CS   = 2;
    localparam int c_LAT_FULL = CS_SETUP + 16*CLK_DIV + CS_HOLD + 1;
    localparam int c_LAT_HELD = 16*CLK_DIV + CS_HOLD + 1;
    localparam int c_CSN_LOW  = CS_SETUP + 16*CLK_DIV + CS_HOLD;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [NUM_CS-1:0] spi_csn;

    logic miso_loop;
    logic miso_tie;
    assign spi_miso = miso_loop ? spi_mosi : miso_tie;

    spi_csn_sequencer #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .NUM_CS  (NUM_CS)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_csn   (spi_csn)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    logic       bit_q[$];

    int   rise_cnt      = 0;
    int   csn0_low_cnt  = 0;
    int   csn0_rise_cnt = 0;
    logic csn1_low_seen = 1'b0;
    logic prev_sclk     = 1'b0;
    logic prev_csn0     = 1'b1;
    logic exp_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Line monitor: checks mosi at each sclk rise against the queued bits
    always @(negedge clk) begin
        if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            if (bit_q.size() > 0) begin
                exp_bit = bit_q.pop_front();
                chk("mosi_at_rise", 32'(spi_mosi), 32'(exp_bit));
            end
        end
        if (spi_csn[0] === 1'b0) csn0_low_cnt++;
        if (spi_csn[0] === 1'b1 && prev_csn0 === 1'b0) csn0_rise_cnt++;
        if (spi_csn[1] === 1'b0) csn1_low_seen = 1'b1;
        prev_sclk = spi_sclk;
        prev_csn0 = spi_csn[0];
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // Clears status, queues expectations, then issues the TXRX write
    task automatic start_xfer(input logic [7:0] b);
        bus_write(2'd1, 32'd0);
        for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
        rx_q.push_back(miso_loop ? b : 8'hFF);
        rise_cnt = 0;
        bus_write(2'd0, {24'd0, b});
    endtask

    // Polls STATUS until done; optionally injects a TXRX write at poll index ovr_at
    task automatic wait_xfer(input int exp_lat, input int ovr_at,
                             output logic [31:0] st, output int irq_k);
        int k;
        bit seen;
        bit is_wr;
        k     = 0;
        seen  = 1'b0;
        irq_k = -1;
        st    = '0;
        while (!seen && k < 200) begin
            is_wr = (k == ovr_at);
            if (is_wr) begin
                address = 2'd0; writedata = 32'h0000_00FF; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                address = 2'd1; writedata = '0; chipselect = 1'b0; write_n = 1'b1;
            end
            @(negedge clk);
            k++;
            if (irq === 1'b1 && irq_k < 0) irq_k = k;
            if (!is_wr && k == 1) chk("busy_after_start", 32'(readdata[0]), 32'd1);
            if (!is_wr && readdata[1] === 1'b1) begin
                seen = 1'b1;
                st   = readdata;
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd1;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else       chk("latency", 32'(k - 1), 32'(exp_lat));
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        bus_read(2'd0, d);
        e = rx_q.pop_front();
        chk(tag, d, {24'd0, e});
        chk("sclk_pulses", 32'(rise_cnt), 32'd8);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] st;
        logic [31:0] d;
        int          irq_k;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        miso_loop = 1'b1; miso_tie = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(spi_csn), 32'h3);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Loopback 0xA5 on cs 0
        bus_write(2'd3, 32'h0000_0001);
        bus_write(2'd2, 32'd0);
        bus_read(2'd3, d);
        chk("control_read", d, 32'h0000_0001);
        csn0_low_cnt = 0; csn1_low_seen = 1'b0;
        start_xfer(8'hA5);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        chk("status_done", st[2:0], 32'b010);
        chk("csn0_low_cycles", 32'(csn0_low_cnt), 32'(c_CSN_LOW));
        chk("csn0_released", 32'(spi_csn[0]), 32'd1);
        check_rx("rx_loop_a5");
        chk("csn1_never_low", 32'(csn1_low_seen), 32'd0);

        // miso tied high, 0x3C
        miso_loop = 1'b0; miso_tie = 1'b1;
        start_xfer(8'h3C);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        check_rx("rx_tied_ff");
        miso_loop = 1'b1;

        // Interrupt enable, clear, and masked
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd1);
        start_xfer(8'h96);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        chk("irq_with_done", 32'(irq_k), 32'(c_LAT_FULL));
        check_rx("rx_96");
        bus_write(2'd1, 32'd0);
        chk("irq_cleared", 32'(irq), 32'd0);
        bus_write(2'd2, 32'd0);
        start_xfer(8'h69);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        chk("irq_masked", 32'(irq_k), 32'hFFFF_FFFF);
        check_rx("rx_69");

        // Chip-select hold-over across two bytes
        bus_write(2'd3, 32'h0000_0101);
        csn0_rise_cnt = 0;
        start_xfer(8'h11);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        chk("csn_held_after_1st", 32'(spi_csn[0]), 32'd0);
        check_rx("rx_11");
        start_xfer(8'h22);
        wait_xfer(c_LAT_HELD, -1, st, irq_k);
        check_rx("rx_22");
        chk("csn_no_rise_between", 32'(csn0_rise_cnt), 32'd0);
        chk("csn_held_after_2nd", 32'(spi_csn[0]), 32'd0);
        bus_write(2'd3, 32'h0000_0001);
        chk("csn_release", 32'(spi_csn[0]), 32'd1);

        // Write while busy mid-transfer
        start_xfer(8'h5A);
        wait_xfer(c_LAT_FULL, 10, st, irq_k);
        chk("ovr_mid", 32'(st[2]), 32'd1);
        check_rx("rx_ovr_orig");

        // Write on the very edge the FSM returns to IDLE
        start_xfer(8'h33);
        wait_xfer(c_LAT_FULL, c_LAT_FULL - 1, st, irq_k);
        check_rx("rx_33");
        bus_read(2'd1, d);
        chk("ovr_at_idle_entry", d[2:0], 32'b110);
        repeat (4) @(negedge clk);
        bus_read(2'd1, d);
        chk("no_start_after_edge_write", 32'(d[0]), 32'd0);
        chk("csn_idle_after_edge_write", 32'(spi_csn), 32'h3);

        // Reset during bit 4 of the shift
        start_xfer(8'hC3);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_csn", 32'(spi_csn), 32'h3);
        chk("midrst_sclk", 32'(spi_sclk), 32'd0);
        chk("midrst_mosi", 32'(spi_mosi), 32'd0);
        reset = 1'b0;
        bit_q.delete();
        rx_q.delete();
        bus_read(2'd1, d);
        chk("midrst_status", d, 32'd0);
        bus_read(2'd0, d);
        chk("midrst_rx", d, 32'd0);
        bus_write(2'd3, 32'h0000_0001);
        start_xfer(8'hE7);
        wait_xfer(c_LAT_FULL, -1, st, irq_k);
        check_rx("rx_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
